// File: rtl/bus_timing_pkg.sv
// bus_timing_pkg
// Shared raster, E-clock and memory-map constants for the clk32 timing
// generator, plus the slot-ownership type and the video address helper.
package bus_timing_pkg;

  // Raster geometry in clk8 periods (horizontal) and lines (vertical)
  localparam logic [8:0]  H_TOTAL   = 9'd352;
  localparam logic [8:0]  H_ACTIVE  = 9'd256;
  localparam logic [8:0]  V_TOTAL   = 9'd370;
  localparam logic [8:0]  V_ACTIVE  = 9'd342;

  // hcount[8:3] value of the per-line sound fetch (hcount 264..271)
  localparam logic [5:0]  SND_SLOT  = 6'd33;

  // E clock: 10 clk8 periods, rising when ecount steps 5->6
  localparam logic [3:0]  E_PERIOD  = 4'd10;
  localparam logic [3:0]  E_RISE_AT = 4'd5;

  // clk32 phases inside one clk8 period
  localparam logic [1:0]  DIV_P     = 2'd1;
  localparam logic [1:0]  DIV_N     = 2'd3;

  // Frame and sound buffer word addresses
  localparam logic [20:0] VID_BASE  = 21'h1FD380;
  localparam logic [20:0] SND_BASE  = 21'h1FFE80;

  // Owner of a 4-clk8 memory cycle, selected by hcount[2]
  typedef enum logic {
    SLOT_VIDEO = 1'b0,
    SLOT_CPU   = 1'b1
  } slot_e;

  // Word address of a pixel fetch: one 32-word row per line, 21-bit wrap
  function automatic logic [20:0] video_word_addr(input logic [8:0] vcount,
                                                  input logic [4:0] word_idx);
    video_word_addr = VID_BASE + {7'd0, vcount, 5'd0} + {16'd0, word_idx};
  endfunction

endpackage

// File: rtl/bus_timing_ctrl_raster_counter.sv
// raster_counter
// Horizontal/vertical raster position pair. hcount runs 0..H_TOTAL-1 and
// vcount steps once per line wrap, running 0..V_TOTAL-1.
// Ports:
//   clk32   in   system clock
//   rst_n   in   asynchronous active-low reset (already release-synchronised)
//   advance in   one-clk32 step enable (clk8_en_p)
//   hcount  out  horizontal position, 9 bits
//   vcount  out  vertical position, 9 bits
//   h_wrap  out  this advance ends the line
//   v_wrap  out  this advance ends the frame
module raster_counter
  import bus_timing_pkg::*;
(
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       advance,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       h_wrap,
  output logic       v_wrap
);

  logic [8:0] hcount_r;
  logic [8:0] vcount_r;
  logic [8:0] hcount_next_s;
  logic [8:0] vcount_next_s;
  logic       h_last_s;
  logic       v_last_s;

  // Next raster position; both counters wrap together at the frame end
  always_comb begin
    h_last_s      = (hcount_r == (H_TOTAL - 9'd1));
    v_last_s      = (vcount_r == (V_TOTAL - 9'd1));
    hcount_next_s = hcount_r;
    vcount_next_s = vcount_r;
    if (h_last_s) begin
      hcount_next_s = 9'd0;
      if (v_last_s) begin
        vcount_next_s = 9'd0;
      end else begin
        vcount_next_s = vcount_r + 9'd1;
      end
    end else begin
      hcount_next_s = hcount_r + 9'd1;
    end
  end

  // Raster position registers, stepped once per clk8
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      hcount_r <= 9'd0;
      vcount_r <= 9'd0;
    end else if (advance) begin
      hcount_r <= hcount_next_s;
      vcount_r <= vcount_next_s;
    end
  end

  assign hcount = hcount_r;
  assign vcount = vcount_r;
  assign h_wrap = advance && h_last_s;
  assign v_wrap = advance && h_last_s && v_last_s;

endmodule

// File: rtl/bus_timing_ctrl.sv
// bus_timing_ctrl
// clk32-domain timing for the Mac Plus core: clk8 enables, E-clock edge
// strobes, raster blanking, CPU/video memory slot arbitration and the RAM
// address mux. All strobes are combinational decodes of registered counters.
// Ports:
//   clk32            in   32.5 MHz system clock
//   _systemReset     in   async active-low reset
//   cpuAddr[20:0]    in   CPU word address A21..A1
//   _cpuAS           in   CPU address strobe (tracing only, no timing effect)
//   clk8_en_p/_n     out  clk8 enable pulses (div==1 / div==3)
//   E_rising/falling out  E-clock edge strobes, clk8_en_p qualified
//   _hblank/_vblank  out  active-low blanking
//   videoBusControl  out  video owns the current memory cycle
//   cpuBusControl    out  CPU owns the current memory cycle
//   memoryLatch      out  data-valid strobe at the end of a memory cycle
//   loadPixels       out  pixel word load qualifier
//   loadSound        out  sound word load qualifier
//   memoryAddr[20:0] out  word address to RAM/ROM
module bus_timing_ctrl
  import bus_timing_pkg::*;
(
  input  logic        clk32,
  input  logic        _systemReset,
  input  logic [20:0] cpuAddr,
  input  logic        _cpuAS,
  output logic        clk8_en_p,
  output logic        clk8_en_n,
  output logic        E_rising,
  output logic        E_falling,
  output logic        _hblank,
  output logic        _vblank,
  output logic        videoBusControl,
  output logic        cpuBusControl,
  output logic        memoryLatch,
  output logic        loadPixels,
  output logic        loadSound,
  output logic [20:0] memoryAddr
);

  logic        rst_sync_r;
  logic [1:0]  div_r;
  logic [3:0]  ecount_r;
  logic [8:0]  hcount_s;
  logic [8:0]  vcount_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        clk8_p_s;
  logic        clk8_n_s;
  logic        hactive_s;
  logic        vactive_s;
  logic        active_s;
  logic        sound_fetch_s;
  logic        video_bus_s;
  logic        latch_s;
  slot_e       slot_s;
  logic [20:0] addr_s;
  logic        unused_s;

  // Reset release is retimed by one clk32 so the counters leave reset on a
  // clean edge; assertion still clears everything immediately.
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      rst_sync_r <= 1'b0;
    end else begin
      rst_sync_r <= 1'b1;
    end
  end

  // clk32 -> clk8 phase divider
  always_ff @(posedge clk32 or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      div_r <= 2'd0;
    end else begin
      div_r <= div_r + 2'd1;
    end
  end

  // Free-running E-clock phase counter, one step per clk8
  always_ff @(posedge clk32 or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      ecount_r <= 4'd0;
    end else if (clk8_p_s) begin
      if (ecount_r == (E_PERIOD - 4'd1)) begin
        ecount_r <= 4'd0;
      end else begin
        ecount_r <= ecount_r + 4'd1;
      end
    end
  end

  raster_counter u_raster (
    .clk32   (clk32),
    .rst_n   (rst_sync_r),
    .advance (clk8_p_s),
    .hcount  (hcount_s),
    .vcount  (vcount_s),
    .h_wrap  (h_wrap_s),
    .v_wrap  (v_wrap_s)
  );

  // Phase, blanking and slot decode from the registered counters
  always_comb begin
    clk8_p_s      = (div_r == DIV_P);
    clk8_n_s      = (div_r == DIV_N);
    hactive_s     = (hcount_s < H_ACTIVE);
    vactive_s     = (vcount_s < V_ACTIVE);
    active_s      = hactive_s && vactive_s;
    // Sound fetch sits outside active display, so it runs on every line
    sound_fetch_s = (hcount_s[8:3] == SND_SLOT);
    slot_s        = slot_e'(hcount_s[2]);
    video_bus_s   = (slot_s == SLOT_VIDEO) && (active_s || sound_fetch_s);
    // Data is valid at the clk8_en_n of the fourth clk8 of the cycle
    latch_s       = clk8_n_s && (hcount_s[1:0] == 2'd3);
  end

  // Address mux: video rows, then the sound word, otherwise the CPU
  always_comb begin
    addr_s = cpuAddr;
    if (video_bus_s && active_s) begin
      addr_s = video_word_addr(vcount_s, hcount_s[7:3]);
    end else if (video_bus_s) begin
      addr_s = SND_BASE + {12'd0, vcount_s};
    end else begin
      addr_s = cpuAddr;
    end
  end

  assign clk8_en_p       = clk8_p_s;
  assign clk8_en_n       = clk8_n_s;
  assign E_rising        = clk8_p_s && (ecount_r == E_RISE_AT);
  assign E_falling       = clk8_p_s && (ecount_r == (E_PERIOD - 4'd1));
  assign _hblank         = hactive_s;
  assign _vblank         = vactive_s;
  assign videoBusControl = video_bus_s;
  assign cpuBusControl   = !video_bus_s;
  assign memoryLatch     = latch_s;
  assign loadPixels      = latch_s && video_bus_s && active_s;
  assign loadSound       = latch_s && sound_fetch_s && (slot_s == SLOT_VIDEO);
  assign memoryAddr      = addr_s;

  // _cpuAS and the wrap flags are observation points only; timing ignores them
  assign unused_s = &{1'b0, _cpuAS, h_wrap_s, v_wrap_s};

endmodule
